// File: rtl/bc_pkg.sv
// Shared types and helpers for the bit-plane accumulator.
package bc_pkg;

  // Controller states: waiting for a burst, accumulating planes, holding a result.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StHold = 2'd2
  } bc_state_e;

  // Plane-count width for the default configuration (PLANES = 8).
  localparam int unsigned PlanesDefault = 8;
  localparam int unsigned NP_W          = $clog2(PlanesDefault + 1);

  // Zero-extend the low w bits of v.
  function automatic logic [63:0] zext(input logic [63:0] v, input int unsigned w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return v & mask;
  endfunction

  // Sign-extend the low w bits of v.
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (v[w-1]) begin
      return v | ~mask;
    end
    return v & mask;
  endfunction

endpackage

// File: rtl/bc_shift_add.sv
// Combinational shift-add step for one bit-plane popcount.
module bc_shift_add
  import bc_pkg::*;
#(
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned SIGNED = 1
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             first_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [ACC_W-1:0] cnt_ext;

  // MSB plane seeds the sum (negated when signed); later planes double and add.
  always_comb begin
    cnt_ext = ACC_W'(zext(64'(cnt_i), CNT_W));
    if (first_i) begin
      acc_o = (SIGNED != 0) ? (ACC_W'(0) - cnt_ext) : cnt_ext;
    end else begin
      acc_o = {acc_i[ACC_W-2:0], 1'b0} + cnt_ext;
    end
  end

endmodule

// File: rtl/bc_plane_accum.sv
// Bit-serial plane accumulator: folds MSB-first popcount beats into one result per burst.
module bc_plane_accum
  import bc_pkg::*;
#(
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned PLANES = 8,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned SIGNED = 1,
  localparam int unsigned NpW   = $clog2(PLANES + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [CNT_W-1:0] in_cnt_i,
  input  logic             in_first_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_acc_o,
  output logic [NpW-1:0]   out_nplanes_o,
  output logic             err_seq_o
);

  bc_state_e        state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [NpW-1:0]   np_q;
  logic [NpW-1:0]   np_d;
  logic [ACC_W-1:0] out_acc_q;
  logic [NpW-1:0]   out_np_q;
  logic             out_valid_q;
  logic             err_q;

  logic accept;
  logic in_acc;
  logic beat_used;
  logic drop;
  logic ends;
  logic seq_err;

  // A held result blocks input unless it is being consumed this cycle.
  assign in_ready_o = (state_q != StHold) | out_ready_i;

  bc_shift_add #(
    .CNT_W (CNT_W),
    .ACC_W (ACC_W),
    .SIGNED(SIGNED)
  ) u_shift_add (
    .acc_i  (acc_q),
    .cnt_i  (in_cnt_i),
    .first_i(in_first_i),
    .acc_o  (acc_d)
  );

  // Beat classification: used for accumulation, dropped, or closing the burst.
  always_comb begin
    accept    = in_valid_i & in_ready_o;
    in_acc    = (state_q == StAcc);
    // A first beat always (re)starts a burst; other beats only count mid-burst.
    beat_used = accept & (in_first_i | in_acc);
    drop      = accept & ~in_first_i & ~in_acc;
    np_d      = in_first_i ? NpW'(1) : np_q + NpW'(1);
    // Reaching the plane limit closes the burst even without in_last.
    ends      = beat_used & (in_last_i | (np_d == NpW'(PLANES)));
    seq_err   = drop | (accept & in_first_i & in_acc) | (ends & ~in_last_i);
  end

  // Controller, running sum, plane counter and registered result.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      np_q        <= '0;
      out_acc_q   <= '0;
      out_np_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (seq_err) begin
        err_q <= 1'b1;
      end

      if (beat_used) begin
        acc_q <= acc_d;
        np_q  <= np_d;
      end

      unique case (state_q)
        StIdle, StAcc: begin
          if (ends) begin
            state_q <= StHold;
          end else if (beat_used) begin
            state_q <= StAcc;
          end
        end
        StHold: begin
          // Input is only accepted here when the result is consumed, so a
          // back-to-back burst can start or even finish in this cycle.
          if (out_ready_i) begin
            if (ends) begin
              state_q <= StHold;
            end else if (beat_used) begin
              state_q <= StAcc;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (ends) begin
        out_acc_q   <= acc_d;
        out_np_q    <= np_d;
        out_valid_q <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_acc_o     = out_acc_q;
  assign out_nplanes_o = out_np_q;
  assign err_seq_o     = err_q;

endmodule

// File: tb/tb_bc_plane_accum.sv
// Directed bench for bc_plane_accum: an unsigned and a signed instance share stimulus.
module tb_bc_plane_accum;
  import bc_pkg::*;

  localparam int unsigned CntW   = 2;
  localparam int unsigned Planes = 8;
  localparam int unsigned AccW   = 12;

  typedef struct {
    bit rstn;
    bit valid;
    int cnt;
    bit first;
    bit last;
    bit ordy;
    bit e_rdy;
    bit e_ov;
    bit chk;
    int e_u;
    int e_s;
    int e_np;
    bit e_err;
  } vec_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              in_valid;
  logic [CntW-1:0]   in_cnt;
  logic              in_first;
  logic              in_last;
  logic              out_ready;
  logic              rdy_u, rdy_s, ov_u, ov_s, err_u, err_s;
  logic [AccW-1:0]   acc_u, acc_s;
  logic [NP_W-1:0]   np_u, np_s;

  int n_checks = 0;
  int n_err    = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  bc_plane_accum #(
    .CNT_W(CntW), .PLANES(Planes), .ACC_W(AccW), .SIGNED(0)
  ) u_dut_u (
    .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_ready_o(rdy_u),
    .in_cnt_i(in_cnt), .in_first_i(in_first), .in_last_i(in_last),
    .out_valid_o(ov_u), .out_ready_i(out_ready), .out_acc_o(acc_u),
    .out_nplanes_o(np_u), .err_seq_o(err_u)
  );

  bc_plane_accum #(
    .CNT_W(CntW), .PLANES(Planes), .ACC_W(AccW), .SIGNED(1)
  ) u_dut_s (
    .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_ready_o(rdy_s),
    .in_cnt_i(in_cnt), .in_first_i(in_first), .in_last_i(in_last),
    .out_valid_o(ov_s), .out_ready_i(out_ready), .out_acc_o(acc_s),
    .out_nplanes_o(np_s), .err_seq_o(err_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Row without result check.
  task automatic pb(input bit rn, input bit va, input int c, input bit f, input bit l,
                    input bit r, input bit er, input bit eo, input bit ee);
    vec_t v;
    v = '{rn, va, c, f, l, r, er, eo, 1'b0, 0, 0, 0, ee};
    tv.push_back(v);
  endtask

  // Row with result check (out_acc for both instances and out_nplanes).
  task automatic pc(input bit rn, input bit va, input int c, input bit f, input bit l,
                    input bit r, input bit er, input bit eo, input int eu, input int es,
                    input int enp, input bit ee);
    vec_t v;
    v = '{rn, va, c, f, l, r, er, eo, 1'b1, eu, es, enp, ee};
    tv.push_back(v);
  endtask

  task automatic drive(input bit rn, input bit va, input int c, input bit f, input bit l,
                       input bit r);
    rstn      = rn;
    in_valid  = va;
    in_cnt    = CntW'(c);
    in_first  = f;
    in_last   = l;
    out_ready = r;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int waited;

    // Reset.
    pc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Unsigned 3,0,1,2 -> 28; signed -> -20.
    pb(1, 1, 3, 1, 0, 1, 1, 0, 0);
    pb(1, 1, 0, 0, 0, 1, 1, 0, 0);
    pb(1, 1, 1, 0, 0, 1, 1, 0, 0);
    pc(1, 1, 2, 0, 1, 1, 1, 1, 28, 4076, 4, 0);
    pb(1, 0, 0, 0, 0, 1, 1, 0, 0);
    // Eight planes of 1: 255 unsigned, -1 signed.
    pb(1, 1, 1, 1, 0, 1, 1, 0, 0);
    for (int k = 0; k < 6; k++) pb(1, 1, 1, 0, 0, 1, 1, 0, 0);
    pc(1, 1, 1, 0, 1, 1, 1, 1, 255, 4095, 8, 0);
    // Back-to-back single-beat bursts, then a 4-beat burst with no bubble.
    pc(1, 1, 3, 1, 1, 1, 1, 1, 3, 4093, 1, 0);
    pc(1, 1, 2, 1, 1, 1, 1, 1, 2, 4094, 1, 0);
    pb(1, 1, 1, 1, 0, 1, 1, 0, 0);
    pb(1, 1, 1, 0, 0, 1, 1, 0, 0);
    pb(1, 1, 1, 0, 0, 1, 1, 0, 0);
    pc(1, 1, 1, 0, 1, 1, 1, 1, 15, 4095, 4, 0);
    // Consumer stalls five cycles: result held, input blocked.
    for (int k = 0; k < 5; k++) pc(1, 1, 1, 1, 1, 0, 0, 1, 15, 4095, 4, 0);
    pb(1, 1, 2, 1, 0, 1, 1, 0, 0);
    pc(1, 1, 1, 0, 1, 1, 1, 1, 5, 4093, 2, 0);
    pb(1, 0, 0, 0, 0, 1, 1, 0, 0);
    // Reset mid-burst, then a fresh burst.
    pb(1, 1, 3, 1, 0, 1, 1, 0, 0);
    pb(1, 1, 0, 0, 0, 1, 1, 0, 0);
    pb(1, 1, 1, 0, 0, 1, 1, 0, 0);
    pc(0, 1, 2, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    pb(1, 1, 3, 1, 0, 1, 1, 0, 0);
    pb(1, 1, 0, 0, 0, 1, 1, 0, 0);
    pb(1, 1, 1, 0, 0, 1, 1, 0, 0);
    pc(1, 1, 2, 0, 1, 1, 1, 1, 28, 4076, 4, 0);
    pb(1, 0, 0, 0, 0, 1, 1, 0, 0);
    // Beat without first in idle: dropped, sticky error.
    pb(1, 1, 1, 0, 0, 1, 1, 0, 1);
    pb(1, 0, 0, 0, 0, 1, 1, 0, 1);
    pc(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    // Nine beats, no last: forced end at the eighth.
    pb(1, 1, 1, 1, 0, 1, 1, 0, 0);
    for (int k = 0; k < 6; k++) pb(1, 1, 1, 0, 0, 1, 1, 0, 0);
    pc(1, 1, 1, 0, 0, 1, 1, 1, 255, 4095, 8, 1);
    pc(1, 1, 1, 0, 0, 0, 0, 1, 255, 4095, 8, 1);
    pb(1, 0, 0, 0, 0, 1, 1, 0, 1);

    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i].rstn, tv[i].valid, tv[i].cnt, tv[i].first, tv[i].last, tv[i].ordy);
      #1;
      check($sformatf("row%0d in_ready", i), 32'(rdy_u), 32'(tv[i].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("row%0d out_valid", i), 32'(ov_u), 32'(tv[i].e_ov));
      check($sformatf("row%0d err_seq", i), 32'(err_u), 32'(tv[i].e_err));
      if (tv[i].chk) begin
        check($sformatf("row%0d out_acc_unsigned", i), 32'(acc_u), 32'(tv[i].e_u));
        check($sformatf("row%0d out_acc_signed", i), 32'(acc_s), 32'(tv[i].e_s));
        check($sformatf("row%0d out_nplanes", i), 32'(np_u), 32'(tv[i].e_np));
      end
    end

    // Restart: first beat arriving mid-burst discards the burst in progress.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    drive(1, 1, 3, 1, 0, 1);
    @(posedge clk);
    #1;
    check("restart err_before", 32'(err_u), 32'd0);
    @(negedge clk);
    drive(1, 1, 1, 1, 0, 1);
    @(posedge clk);
    #1;
    check("restart err_after", 32'(err_u), 32'd1);
    @(negedge clk);
    drive(1, 1, 2, 0, 1, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waited = 0;
    while (!ov_u && waited < 4) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("restart out_valid", 32'(ov_u), 32'd1);
    check("restart latency", 32'(waited), 32'd0);
    check("restart out_acc_unsigned", 32'(acc_u), 32'd4);
    check("restart out_acc_signed", 32'(acc_s), 32'd0);
    check("restart out_nplanes", 32'(np_u), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
